datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state updates on the rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port ctrlwrd, input, 15 bits: control word. Bit assignment: j=0, co=1, ce=2, oi=3, bi=4, su=5, so=6, ao=7, ai=8, ii=9, io=10, ro=11, ri=12, mi=13, hlt=14.
REQ-004 SHALL have port instruction, output, 4 bits: IR[7:4], the opcode fed to the controller.
REQ-005 SHALL have port bus, output, 8 bits: current internal bus value, for observation.
REQ-006 SHALL have port pc, output, 4 bits: program counter.
REQ-007 SHALL have port outvalue, output, 8 bits: output register.
REQ-008 SHALL have port outvalid, output, 1 bit: one-cycle pulse on each output-register load.
REQ-009 SHALL have port carry, output, 1 bit: registered carry flag.
REQ-010 SHALL have port halted, output, 1 bit: sticky halt indicator.

Function
REQ-011 SHALL drive bus combinationally, in this priority: ro → RAM[MAR]; io → {4'b0, IR[3:0]}; ao → A; so → ALU result; co → {4'b0, PC}; no output enable → 8'h00.
REQ-012 SHALL compute ALU combinationally as a 9-bit value: A + B when su=0, and A + (~B) + 1 when su=1; result is bits [7:0], carry-out is bit 8.
REQ-013 SHALL load MAR from bus[3:0] on mi.
REQ-014 SHALL write bus into RAM[MAR] on ri; RAM is 16x8 with a combinational read.
REQ-015 SHALL load IR from bus on ii.
REQ-016 SHALL load A from bus on ai.
REQ-017 SHALL load B from bus on bi.
REQ-018 SHALL load the output register from bus on oi and assert outvalid for exactly that following cycle; otherwise outvalid=0.
REQ-019 SHALL load carry from ALU bit 8 only when so and ai are both set; otherwise carry holds.
REQ-020 SHALL load PC from bus[3:0] on j; on ce, PC SHALL increment modulo 16 (15→0); j SHALL win when j and ce are both set.
REQ-021 SHALL set halted on hlt; once set, halted stays 1 until reset.
REQ-022 While halted, SHALL suppress all register and RAM writes, except the program port in REQ-027; bus and outputs keep reflecting held state.
REQ-023 SHALL sample every register with the bus value and ctrlwrd as they stand immediately before the edge. Example: ro+ai loads A with the pre-edge RAM[MAR]; ri+ro at the same address leaves RAM unchanged.
REQ-024 An all-zero ctrlwrd SHALL change no state, and outvalid SHALL be 0.

Reset
REQ-025 On resetn=0, asynchronously, SHALL clear PC, MAR, IR, A, B, outvalue, outvalid, carry and halted; bus then reads 8'h00.
REQ-026 Reset SHALL NOT alter RAM contents; reset mid-instruction SHALL abandon it with no partial writes after assertion.

Configuration
REQ-027 With DATAPATH_PROG_EN defined, SHALL add these inputs: progwe (1 bit), progaddr (4 bits), progdata (8 bits). On a rising edge with progwe=1, SHALL write RAM[progaddr]=progdata, even while halted, taking priority over ri. Without the macro, these ports SHALL be absent and RAM SHALL power up with all 16 locations 8'h00.

Verification
REQ-028 Bench SHALL cover fetch: RAM[0]=8'h1E, ctrlwrd=mi|co, then ro|ii|ce → IR=8'h1E, instruction=4'h1, PC=1.
REQ-029 Bench SHALL cover LDA/ADD: RAM[14]=8'h05, RAM[15]=8'hFE; A←RAM[14], B←RAM[15], so|ai → A=8'h03, carry=1.
REQ-030 Bench SHALL cover SUB: A=8'h03, B=8'h05, so|su|ai → A=8'hFE, carry=0.
REQ-031 Bench SHALL cover OUT and JMP: ao|oi → outvalue=A and outvalid high for one cycle only; IR=8'h63, io|j|ce → PC=3.
REQ-032 Bench SHALL cover PC wrap and halt: PC=15, ce → PC=0; hlt, then ai|ce → halted=1, A and PC unchanged.
REQ-033 Bench SHALL cover async reset mid-run: resetn low between edges → all REQ-025 registers read 0 before the next edge, and RAM is unchanged.

Source files
------------

// File: rtl/datapath.sv
// 8-bit bus-oriented datapath: PC, MAR, IR, A, B, output register, carry and
// halt flags around a 16x8 RAM, all steered by a 15-bit control word.
// Optional feature macro: DATAPATH_PROG_EN adds a RAM program port
// (progwe/progaddr/progdata) that writes even while halted and beats ri.
module datapath (
    input  logic        clk,
    input  logic        resetn,
    input  logic [14:0] ctrlwrd,
`ifdef DATAPATH_PROG_EN
    input  logic        progwe,
    input  logic [3:0]  progaddr,
    input  logic [7:0]  progdata,
`endif
    output logic [3:0]  instruction,
    output logic [7:0]  bus,
    output logic [3:0]  pc,
    output logic [7:0]  outvalue,
    output logic        outvalid,
    output logic        carry,
    output logic        halted
);

    // control word decode
    logic c_j, c_co, c_ce, c_oi, c_bi, c_su, c_so, c_ao;
    logic c_ai, c_ii, c_io, c_ro, c_ri, c_mi, c_hlt;
    assign {c_hlt, c_mi, c_ri, c_ro, c_io, c_ii, c_ai, c_ao,
            c_so, c_su, c_bi, c_oi, c_ce, c_co, c_j} = ctrlwrd;

    logic [3:0] pc_q, pc_d, mar_q, mar_d;
    logic [7:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
    logic       outv_q, outv_d, carry_q, carry_d, halt_q, halt_d;
    logic [8:0] alu;
    logic       wen;

    // RAM is not touched by reset; the declaration value gives the
    // all-zero power-up contents.
    logic [7:0] mem_q [16] = '{default: 8'h00};

    // Once halted, only the program port may still write state.
    assign wen = ~halt_q;

    // Subtraction is A + ~B + 1, so carry=1 means "no borrow".
    assign alu = {1'b0, a_q} + {1'b0, (c_su ? ~b_q : b_q)} + {8'b0, c_su};

    // Bus source select, highest priority first; idle bus reads zero.
    always_comb begin
        bus = 8'h00;
        if      (c_ro) bus = mem_q[mar_q];
        else if (c_io) bus = {4'b0, ir_q[3:0]};
        else if (c_ao) bus = a_q;
        else if (c_so) bus = alu[7:0];
        else if (c_co) bus = {4'b0, pc_q};
    end

    // Next-state for every register, all sampled from the pre-edge bus.
    always_comb begin
        pc_d    = pc_q;
        mar_d   = mar_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        carry_d = carry_q;
        halt_d  = halt_q;
        outv_d  = wen & c_oi;
        if (wen) begin
            if (c_mi) mar_d = bus[3:0];
            if (c_ii) ir_d  = bus;
            if (c_ai) a_d   = bus;
            if (c_bi) b_d   = bus;
            if (c_oi) out_d = bus;
            if (c_so && c_ai) carry_d = alu[8];
            if (c_j)       pc_d = bus[3:0];
            else if (c_ce) pc_d = pc_q + 4'd1;
            if (c_hlt) halt_d = 1'b1;
        end
    end

    // Register bank with asynchronous active-low clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q    <= '0;
            mar_q   <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            outv_q  <= 1'b0;
            carry_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            mar_q   <= mar_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            outv_q  <= outv_d;
            carry_q <= carry_d;
            halt_q  <= halt_d;
        end
    end

    // RAM write; blocked while reset is held so an abandoned step leaves
    // no partial write behind.
    always_ff @(posedge clk) begin
        if (resetn) begin
`ifdef DATAPATH_PROG_EN
            if (progwe) mem_q[progaddr] <= progdata;
            else
`endif
            if (wen && c_ri) mem_q[mar_q] <= bus;
        end
    end

    assign instruction = ir_q[7:4];
    assign pc          = pc_q;
    assign outvalue    = out_q;
    assign outvalid    = outv_q;
    assign carry       = carry_q;
    assign halted      = halt_q;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath. RAM contents are built through the datapath
// itself (shift-and-add in A, then ao|ri), so the default build needs no
// program port.
module tb_datapath;

    localparam logic [14:0] J   = 15'h0001, CO = 15'h0002, CE = 15'h0004;
    localparam logic [14:0] OI  = 15'h0008, BI = 15'h0010, SU = 15'h0020;
    localparam logic [14:0] SO  = 15'h0040, AO = 15'h0080, AI = 15'h0100;
    localparam logic [14:0] II  = 15'h0200, IO = 15'h0400, RO = 15'h0800;
    localparam logic [14:0] RI  = 15'h1000, MI = 15'h2000, HLT = 15'h4000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [14:0] ctrlwrd;
    logic [3:0]  instruction, pc;
    logic [7:0]  bus, outvalue;
    logic        outvalid, carry, halted;
`ifdef DATAPATH_PROG_EN
    logic        progwe = 1'b0;
    logic [3:0]  progaddr = 4'h0;
    logic [7:0]  progdata = 8'h00;
`endif

    int n_chk = 0;
    int n_err = 0;

    datapath dut (
        .clk(clk), .resetn(resetn), .ctrlwrd(ctrlwrd),
`ifdef DATAPATH_PROG_EN
        .progwe(progwe), .progaddr(progaddr), .progdata(progdata),
`endif
        .instruction(instruction), .bus(bus), .pc(pc),
        .outvalue(outvalue), .outvalid(outvalid), .carry(carry),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // apply a control word across one rising edge, sample 1ns later
    task automatic step(input logic [14:0] cw);
        ctrlwrd = cw;
        @(posedge clk);
        #1;
    endtask

    // apply a control word without an edge, to look at the bus
    task automatic peek(input logic [14:0] cw);
        ctrlwrd = cw;
        #1;
    endtask

    // A <= v by doubling and adding 1; needs PC==1 (co supplies the 1)
    task automatic build(input logic [7:0] v);
        step(AI);
        for (int i = 7; i >= 0; i--) begin
            step(AO | BI);
            step(SO | AI);
            if (v[i]) begin
                step(CO | BI);
                step(SO | AI);
            end
        end
    endtask

    task automatic poke(input logic [3:0] addr, input logic [7:0] val);
        build({4'h0, addr});
        step(AO | MI);
        build(val);
        step(AO | RI);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn  = 1'b0;
        ctrlwrd = '0;
        #12;
        check("rst pc", pc, 0);
        check("rst bus", bus, 0);
        check("rst instr", instruction, 0);
        check("rst outvalue", outvalue, 0);
        check("rst outvalid", outvalid, 0);
        check("rst carry", carry, 0);
        check("rst halted", halted, 0);
        @(negedge clk);
        resetn = 1'b1;

        // idle control word changes nothing
        step('0);
        check("idle pc", pc, 0);
        check("idle outvalid", outvalid, 0);
        check("idle bus", bus, 0);

        step(CE);
        check("ce pc", pc, 1);
        step(CO | BI);
        check("co bus", bus, 8'h01);

        poke(4'd14, 8'h05);
        poke(4'd15, 8'hFE);
        poke(4'd0,  8'h1E);

        // short reset between edges; RAM must survive
        #2 resetn = 1'b0;
        #2 resetn = 1'b1;
        check("pulse rst pc", pc, 0);

        // fetch
        step(MI | CO);
        step(RO | II | CE);
        check("fetch instr", instruction, 4'h1);
        check("fetch pc", pc, 4'h1);
        check("fetch bus ro", bus, 8'h1E);
        peek(IO);
        check("io bus", bus, 8'h0E);

        // MAR=15 via ALU (14+1), then B=RAM[15], A=RAM[14]
        step(CO | BI);
        step(IO | AI);
        step(SO | MI);
        step(RO | BI);
        step(IO | MI);
        step(RO | AI);
        peek(AO);
        check("lda A", bus, 8'h05);
        peek(SO);
        check("alu add comb", bus, 8'h03);
        step(SO | AI);
        check("add carry", carry, 1);
        peek(AO);
        check("add A", bus, 8'h03);

        // SUB: 03 - 05
        step(RO | BI);
        step(SO | SU | AI);
        check("sub carry", carry, 0);
        peek(AO);
        check("sub A", bus, 8'hFE);

        // ri+ro at the same address leaves RAM as it was
        step(RO | RI);
        peek(RO);
        check("ro ri ram", bus, 8'h05);

        // OUT
        step(AO | OI);
        check("out value", outvalue, 8'hFE);
        check("out valid", outvalid, 1);
        step('0);
        check("out valid drop", outvalid, 0);
        check("out value hold", outvalue, 8'hFE);

        // PC wrap
        build(8'h0F);
        step(AO | J);
        check("jmp pc15", pc, 4'hF);
        step(CE);
        check("pc wrap", pc, 4'h0);
        step(CE);

        // JMP: j beats ce
        build(8'h63);
        step(AO | II);
        check("ir 63 instr", instruction, 4'h6);
        step(IO | J | CE);
        check("jmp pc", pc, 4'h3);

        // halt
        step(HLT);
        check("halted", halted, 1);
        step(AI | CE);
        check("halt pc hold", pc, 4'h3);
        peek(AO);
        check("halt A hold", bus, 8'h63);
        step(AO | OI);
        check("halt no outvalid", outvalid, 0);
        check("halt outvalue hold", outvalue, 8'hFE);
        step('0);
        check("halted sticky", halted, 1);

        // async reset mid-cycle, then held across an edge with ri active
        ctrlwrd = RI | AI | CE;
        #2 resetn = 1'b0;
        #1;
        check("async pc", pc, 0);
        check("async instr", instruction, 0);
        check("async outvalue", outvalue, 0);
        check("async outvalid", outvalid, 0);
        check("async carry", carry, 0);
        check("async halted", halted, 0);
        check("async bus", bus, 0);
        peek(AO);
        check("async A", bus, 0);
        peek(SO);
        check("async A+B", bus, 0);
        ctrlwrd = RI | AI | CE;
        @(posedge clk);
        #1;
        check("held rst pc", pc, 0);
        resetn = 1'b1;
        peek(RO);
        check("ram0 kept", bus, 8'h1E);

        step(CE);
        build(8'h0E);
        step(AO | MI);
        peek(RO);
        check("ram14 kept", bus, 8'h05);
        build(8'h0F);
        step(AO | MI);
        peek(RO);
        check("ram15 kept", bus, 8'hFE);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
